// File: rtl/hack_alu_reg.sv
// Registered Hack ALU: six control bits select the function of x and y.
// The result and its zero/negative flags are captured one cycle after in_valid.
module hack_alu_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
);

  logic [WIDTH-1:0] x1, x2, y1, y2, r, o;

  always_comb begin
    x1 = zx ? '0 : x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? '0 : y;
    y2 = ny ? ~y1 : y1;
    r  = f ? (x2 + y2) : (x2 & y2);
    o  = no ? ~r : r;
  end

  logic [WIDTH-1:0] out_d, out_q;
  logic             zr_d, zr_q;
  logic             ng_d, ng_q;
  logic             out_valid_d, out_valid_q;

  // Hold path is selected purely by in_valid, so unknown controls on idle
  // cycles never reach the registers.
  always_comb begin
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = o;
      zr_d        = (o == '0);
      ng_d        = o[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hack_alu_reg.sv
// Directed bench for hack_alu_reg: reset, canonical functions, wrap, hold,
// mid-operation reset and a sweep of all 64 control codes.
module tb_hack_alu_reg;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x, y;
  logic         zx, nx, zy, ny, f, no;
  logic [W-1:0] out;
  logic         zr, ng, out_valid;

  int checks   = 0;
  int failures = 0;

  hack_alu_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out), .zr(zr), .ng(ng), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ctrl is written in the usual string order {zx,nx,zy,ny,f,no}
  task automatic drive(input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [5:0] ctrl, input logic v);
    x = xv;
    y = yv;
    {zx, nx, zy, ny, f, no} = ctrl;
    in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] exp_out, input logic exp_v);
    $display("txn %s out=0x%04h zr=%0b ng=%0b vld=%0b", tag, out, zr, ng, out_valid);
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".zr"}, 32'(zr), 32'(exp_out == '0));
    check({tag, ".ng"}, 32'(ng), 32'(exp_out[W-1]));
    check({tag, ".vld"}, 32'(out_valid), 32'(exp_v));
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                           input logic [5:0] c);
    logic [W-1:0] a, b, res;
    a = c[5] ? {W{1'b0}} : xv;
    if (c[4]) a = ~a;
    b = c[3] ? {W{1'b0}} : yv;
    if (c[2]) b = ~b;
    if (c[1]) res = a + b;
    else      res = a & b;
    if (c[0]) res = ~res;
    return res;
  endfunction

  typedef struct {
    string        name;
    logic [5:0]   ctrl;
    logic [W-1:0] exp_out;
  } vec_t;

  // Hand-computed for x=0x0000, y=0x1111
  vec_t canon[18] = '{
    '{"zero",  6'b101010, 16'h0000},
    '{"one",   6'b111111, 16'h0001},
    '{"neg1",  6'b111010, 16'hFFFF},
    '{"x",     6'b001100, 16'h0000},
    '{"y",     6'b110000, 16'h1111},
    '{"notx",  6'b001101, 16'hFFFF},
    '{"noty",  6'b110001, 16'hEEEE},
    '{"negx",  6'b001111, 16'h0000},
    '{"negy",  6'b110011, 16'hEEEF},
    '{"xp1",   6'b011111, 16'h0001},
    '{"yp1",   6'b110111, 16'h1112},
    '{"xm1",   6'b001110, 16'hFFFF},
    '{"ym1",   6'b110010, 16'h1110},
    '{"xpy",   6'b000010, 16'h1111},
    '{"xmy",   6'b010011, 16'hEEEF},
    '{"ymx",   6'b000111, 16'h1111},
    '{"xandy", 6'b000000, 16'h0000},
    '{"xory",  6'b010101, 16'h1111}
  };

  initial begin
    logic [W-1:0] xs, ys;
    logic [5:0]   c;

    rst_n = 1'b0;
    drive(16'h1234, 16'h0001, 6'b000010, 1'b1);
    step();
    expect_res("rst0", 16'h0000, 1'b0);
    step();
    expect_res("rst1", 16'h0000, 1'b0);

    rst_n = 1'b1;
    drive(16'h1234, 16'h0001, 6'b000010, 1'b1);
    step();
    expect_res("post_rst", 16'h1235, 1'b1);

    foreach (canon[i]) begin
      drive(16'h0000, 16'h1111, canon[i].ctrl, 1'b1);
      step();
      expect_res(canon[i].name, canon[i].exp_out, 1'b1);
    end

    drive(16'h7FFF, 16'h0001, 6'b000010, 1'b1);
    step();
    expect_res("wrap_7fff", 16'h8000, 1'b1);
    drive(16'hFFFF, 16'h0001, 6'b000010, 1'b1);
    step();
    expect_res("wrap_ffff", 16'h0000, 1'b1);

    // Register 0xEEEF, then idle three cycles with toggling inputs
    drive(16'h0000, 16'h1111, 6'b010011, 1'b1);
    step();
    expect_res("hold_load", 16'hEEEF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(16'h5A5A ^ 16'(k), 16'hA5A5 + 16'(k), 6'(6'b101010 + k), 1'b0);
      step();
      expect_res($sformatf("hold%0d", k), 16'hEEEF, 1'b0);
    end

    drive(16'h0000, 16'h1111, 6'b110000, 1'b1);
    rst_n = 1'b0;
    step();
    expect_res("mid_rst", 16'h0000, 1'b0);
    rst_n = 1'b1;

    // Back-to-back sweep of every control code; zx toggles fastest
    for (int p = 0; p < 3; p++) begin
      xs = (p == 0) ? 16'h0000 : W'($urandom);
      ys = (p == 0) ? 16'h1111 : W'($urandom);
      for (int i = 0; i < 64; i++) begin
        c = {i[0], i[1], i[2], i[3], i[4], i[5]};
        drive(xs, ys, c, 1'b1);
        step();
        expect_res($sformatf("sw%0d_%06b", p, c), ref_alu(xs, ys, c), 1'b1);
      end
    end

    in_valid = 1'b0;
    step();
    check("final_vld", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_alu_reg.md
Name: hack_alu_reg

Overview:
- Registered implementation of the Hack-platform ALU.
- Computes one of the Hack ALU functions of two WIDTH-bit operands, selected by six control bits (zx, nx, zy, ny, f, no).
- Registers the result together with zero (zr) and negative (ng) flags.
- Sits in the CPU datapath between the D/A-M operand sources and the destination register write-back.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and controls valid this cycle; result is captured at this edge
- x  input  WIDTH  operand X
- y  input  WIDTH  operand Y
- zx  input  1  zero X
- nx  input  1  bitwise-negate X (after zx)
- zy  input  1  zero Y
- ny  input  1  bitwise-negate Y (after zy)
- f  input  1  1 = add, 0 = bitwise AND
- no  input  1  bitwise-negate result
- out  output  WIDTH  registered result
- zr  output  1  registered flag, 1 when out == 0
- ng  output  1  registered flag, 1 when out[WIDTH-1] == 1
- out_valid  output  1  one-cycle pulse, high when out/zr/ng were updated at the previous edge

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - Synchronous active-low reset, sampled on the edge.
  - rst_n=0 at an edge: out=0, zr=1, ng=0, out_valid=0, regardless of in_valid.
  - Reset mid-operation discards the in-flight result; no partial updates.
- Combinational datapath, evaluated in order:
  - x1 = zx ? 0 : x
  - x2 = nx ? ~x1 : x1
  - y1 = zy ? 0 : y
  - y2 = ny ? ~y1 : y1
  - r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2)
  - o = no ? ~r : r
- Arithmetic rules:
  - The add is unsigned WIDTH-bit.
  - Carry-out is discarded; no overflow flag.
  - Signed wrap is allowed, e.g. 0x7FFF+1 = 0x8000.
- Register update:
  - rst_n=1 and in_valid=1 at an edge: out<=o, zr<=(o==0), ng<=o[WIDTH-1], out_valid<=1.
  - rst_n=1 and in_valid=0: out, zr, ng hold their previous values; out_valid<=0.
- Latency: exactly 1 cycle from input sample to registered output. Back-to-back in_valid every cycle is supported at full throughput; there is no backpressure.
- Invariant at all times, including after reset: zr == (out == 0) and ng == out[WIDTH-1].
- X/Z on control inputs while in_valid=0 must not disturb the registered outputs.
- Canonical Hack function encodings (zx nx zy ny f no), all required correct:
  - 0: 101010
  - 1: 111111
  - -1: 111010
  - x: 001100
  - y: 110000
  - !x: 001101
  - !y: 110001
  - -x: 001111
  - -y: 110011
  - x+1: 011111
  - y+1: 110111
  - x-1: 001110
  - y-1: 110010
  - x+y: 000010
  - x-y: 010011
  - y-x: 000111
  - x&y: 000000
  - x|y: 010101
- The remaining 46 control combinations must follow the datapath equations exactly.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, x=0x1234 -> out=0x0000, zr=1, ng=0, out_valid=0. Release rst_n; the next edge with in_valid=1 produces a valid result one cycle later.
- Constants: x=0x0000, y=0x1111. Controls 101010 -> out=0x0000, zr=1. Controls 111111 -> out=0x0001, zr=0, ng=0. Controls 111010 -> out=0xFFFF, ng=1. Each appears exactly 1 cycle after the sampling edge with out_valid=1.
- Arithmetic, x=0x0000, y=0x1111:
  - 000010 (x+y) -> 0x1111
  - 010011 (x-y) -> 0xEEEF, ng=1
  - 000111 (y-x) -> 0x1111
  - 000000 (x&y) -> 0x0000, zr=1
  - 010101 (x|y) -> 0x1111
- Wrap: x=0x7FFF, y=0x0001, 000010 -> out=0x8000, ng=1, zr=0. Also x=0xFFFF, y=0x0001 -> out=0x0000, zr=1, carry discarded.
- Hold and pulse: a result is registered, then in_valid=0 for 3 cycles while x/y/controls toggle -> out/zr/ng unchanged, out_valid=0. Assert rst_n=0 during a valid cycle -> outputs go to reset values at that edge.
- Exhaustive sweep: x=0x0000, y=0x1111, then random x/y. Cycle all 64 control combinations with in_valid=1 every cycle (zx toggling fastest, no slowest). Compare every registered output against a reference model of the datapath equations, 1-cycle delayed, including the zr/ng invariant.
